// File: rtl/ghash_pkg.sv
// Shared definitions for the GHASH stage-1 feeder: block widths, feeder
// FSM state encoding and an all-zero block constant.
package ghash_pkg;

   localparam int unsigned NB_BLOCK = 128;
   localparam int unsigned N_BLOCKS = 2;
   localparam int unsigned NB_DATA  = N_BLOCKS * NB_BLOCK;

   localparam logic [NB_BLOCK-1:0] ZERO_BLOCK = '0;

   typedef enum logic [1:0] {
      EVEN = 2'd0,
      ODD  = 2'd1,
      WAIT = 2'd2
   } feeder_state_e;

endpackage

// File: rtl/ghash_stage1_feeder_if.sv
// Input block stream into the GHASH stage-1 feeder.
//   data_block : 128-bit GHASH input block X_i
//   valid      : block valid; accepted when valid && ready
//   sof / eof  : first / last block of a message
//   ready      : feeder can accept a block
// master = block producer, slave = feeder.
interface ghash_stage1_feeder_if;
   import ghash_pkg::*;

   logic [NB_BLOCK-1:0] data_block;
   logic                valid;
   logic                sof;
   logic                eof;
   logic                ready;

   modport master (output data_block, valid, sof, eof, input ready);
   modport slave  (input data_block, valid, sof, eof, output ready);

endinterface

// File: rtl/ghash_fb_latency_counter.sv
// Load/decrement countdown used to hold off the feeder until the GHASH
// accumulator feedback for the previous pair is available.
//   i_clock, i_reset : clock, async active-high reset
//   i_load, i_load_val : load the counter (has priority over decrement)
//   i_dec            : decrement by one, saturating at zero
//   o_done_c         : combinational, high when the count is 1 (last wait cycle)
module ghash_fb_latency_counter #(
   parameter int unsigned NB_LAT_CNT = 4
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_load,
   input  logic [NB_LAT_CNT-1:0] i_load_val,
   input  logic                  i_dec,
   output logic                  o_done_c
);

   logic [NB_LAT_CNT-1:0] count_q;

   // Countdown register
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         count_q <= '0;
      end else if (i_load) begin
         count_q <= i_load_val;
      end else if (i_dec && (count_q != '0)) begin
         count_q <= count_q - NB_LAT_CNT'(1);
      end
   end

   assign o_done_c = (count_q == NB_LAT_CNT'(1));

endmodule

// File: rtl/ghash_stage1_feeder.sv
// Producer side of the GHASH stage-1 pipe register. Packs incoming blocks
// into even/odd pairs, selects the matching H-power pair, muxes the
// accumulator feedback (zero on the first pair of a message) and holds off
// new input for FB_LAT cycles after every non-final pair.
//   i_clock, i_reset   : clock, async active-high reset
//   blk_if             : input block stream (data/valid/sof/eof/ready)
//   i_h_key, i_h_key_sq: H and H^2, stable for the whole message
//   i_ghash_acc        : accumulator fed back from the end of the pipe
//   o_data_x_even/odd  : pair data (odd = 0 for a single leftover block)
//   o_h_pow_pair       : {even power, odd power}
//   o_feedback_mux     : 0 on first pair, else sampled i_ghash_acc
//   o_valid, o_last    : issue pulse, and "pair ends the message"
//   o_stall            : high while waiting for feedback
module ghash_stage1_feeder
   import ghash_pkg::*;
#(
   parameter int unsigned FB_LAT     = 3,
   parameter int unsigned NB_LAT_CNT = 4
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   ghash_stage1_feeder_if.slave blk_if,
   input  logic [NB_BLOCK-1:0]  i_h_key,
   input  logic [NB_BLOCK-1:0]  i_h_key_sq,
   input  logic [NB_BLOCK-1:0]  i_ghash_acc,
   output logic [NB_BLOCK-1:0]  o_data_x_even,
   output logic [NB_BLOCK-1:0]  o_data_x_odd,
   output logic [NB_DATA-1:0]   o_h_pow_pair,
   output logic [NB_BLOCK-1:0]  o_feedback_mux,
   output logic                 o_valid,
   output logic                 o_last,
   output logic                 o_stall
);

   feeder_state_e       state_q, state_d;
   logic                first_q, first_d;
   logic [NB_BLOCK-1:0] even_hold_q, even_hold_d;
   logic                ready_q, ready_d;
   logic [NB_BLOCK-1:0] x_even_d, x_odd_d, fb_d;
   logic [NB_DATA-1:0]  pair_d;
   logic                valid_d, last_d, stall_d;
   logic                cnt_load, cnt_dec, cnt_done_c;
   logic                accept_c;

   assign accept_c     = blk_if.valid && ready_q;
   assign blk_if.ready = ready_q;

   ghash_fb_latency_counter #(
      .NB_LAT_CNT (NB_LAT_CNT)
   ) u_lat_cnt (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_load     (cnt_load),
      .i_load_val (NB_LAT_CNT'(FB_LAT)),
      .i_dec      (cnt_dec),
      .o_done_c   (cnt_done_c)
   );

   // State and output registers
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q        <= EVEN;
         first_q        <= 1'b1;
         even_hold_q    <= ZERO_BLOCK;
         ready_q        <= 1'b1;
         o_data_x_even  <= ZERO_BLOCK;
         o_data_x_odd   <= ZERO_BLOCK;
         o_h_pow_pair   <= '0;
         o_feedback_mux <= ZERO_BLOCK;
         o_valid        <= 1'b0;
         o_last         <= 1'b0;
         o_stall        <= 1'b0;
      end else begin
         state_q        <= state_d;
         first_q        <= first_d;
         even_hold_q    <= even_hold_d;
         ready_q        <= ready_d;
         o_data_x_even  <= x_even_d;
         o_data_x_odd   <= x_odd_d;
         o_h_pow_pair   <= pair_d;
         o_feedback_mux <= fb_d;
         o_valid        <= valid_d;
         o_last         <= last_d;
         o_stall        <= stall_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      first_d     = first_q;
      even_hold_d = even_hold_q;
      x_even_d    = o_data_x_even;
      x_odd_d     = o_data_x_odd;
      pair_d      = o_h_pow_pair;
      fb_d        = o_feedback_mux;
      valid_d     = 1'b0;
      last_d      = 1'b0;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;

      case (state_q)
         EVEN: begin
            if (accept_c) begin
               even_hold_d = blk_if.data_block;
               first_d     = blk_if.sof;
               if (blk_if.eof) begin
                  // Single leftover block: Y' = (Y + X)*H
                  x_even_d = blk_if.data_block;
                  x_odd_d  = ZERO_BLOCK;
                  pair_d   = {i_h_key, ZERO_BLOCK};
                  fb_d     = blk_if.sof ? ZERO_BLOCK : i_ghash_acc;
                  valid_d  = 1'b1;
                  last_d   = 1'b1;
               end else begin
                  state_d = ODD;
               end
            end
         end
         ODD: begin
            if (accept_c) begin
               // Full pair: Y' = (Y + Xe)*H^2 + Xo*H
               x_even_d = even_hold_q;
               x_odd_d  = blk_if.data_block;
               pair_d   = {i_h_key_sq, i_h_key};
               fb_d     = first_q ? ZERO_BLOCK : i_ghash_acc;
               valid_d  = 1'b1;
               last_d   = blk_if.eof;
               if (blk_if.eof) begin
                  state_d = EVEN;
               end else begin
                  state_d  = WAIT;
                  cnt_load = 1'b1;
               end
            end
         end
         WAIT: begin
            cnt_dec = 1'b1;
            if (cnt_done_c) begin
               state_d = EVEN;
            end
         end
         default: begin
            state_d = EVEN;
         end
      endcase

      // Ready/stall track the state being entered so they are registered
      ready_d = (state_d != WAIT);
      stall_d = (state_d == WAIT);
   end

endmodule

// File: tb/tb_ghash_stage1_feeder.sv
module tb_ghash_stage1_feeder;
   import ghash_pkg::*;

   localparam int unsigned FB_LAT = 3;

   typedef logic [NB_BLOCK-1:0] blk_t;
   typedef struct packed {
      blk_t               even;
      blk_t               odd;
      logic [NB_DATA-1:0] pair;
      blk_t               fb;
      logic               last;
      logic [31:0]        due;
   } exp_t;

   logic        i_clock = 1'b0;
   logic        i_reset = 1'b1;
   blk_t        h, h2, acc;
   blk_t        o_data_x_even, o_data_x_odd, o_feedback_mux;
   logic [NB_DATA-1:0] o_h_pow_pair;
   logic        o_valid, o_last, o_stall;

   ghash_stage1_feeder_if bif ();

   exp_t        exp_q[$];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] cyc = 0;
   int          remaining = 0;
   exp_t        mon_e;

   ghash_stage1_feeder #(
      .FB_LAT     (FB_LAT),
      .NB_LAT_CNT (4)
   ) dut (
      .i_clock        (i_clock),
      .i_reset        (i_reset),
      .blk_if         (bif),
      .i_h_key        (h),
      .i_h_key_sq     (h2),
      .i_ghash_acc    (acc),
      .o_data_x_even  (o_data_x_even),
      .o_data_x_odd   (o_data_x_odd),
      .o_h_pow_pair   (o_h_pow_pair),
      .o_feedback_mux (o_feedback_mux),
      .o_valid        (o_valid),
      .o_last         (o_last),
      .o_stall        (o_stall)
   );

   always #5 i_clock = ~i_clock;
   always @(posedge i_clock) cyc <= cyc + 32'd1;

   task automatic check(input string name, input logic [NB_DATA-1:0] act,
                        input logic [NB_DATA-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic blk_t rnd_blk();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic idle(input int n);
      bif.valid = 1'b0;
      bif.sof   = 1'b0;
      bif.eof   = 1'b0;
      repeat (n) begin
         @(posedge i_clock);
         #1;
      end
   endtask

   // Present one block, wait (bounded) for acceptance; queue the expected
   // pair if this block completes one.
   task automatic put(input blk_t d, input logic sof, input logic eof,
                      input blk_t acc_v, input bit issues, input exp_t e);
      int guard;
      bif.valid      = 1'b1;
      bif.data_block = d;
      bif.sof        = sof;
      bif.eof        = eof;
      acc            = acc_v;
      guard          = 0;
      while (bif.ready !== 1'b1 && guard < 200) begin
         @(posedge i_clock);
         #1;
         guard++;
      end
      if (guard >= 200) check("ready_timeout", 1, 0);
      if (issues) begin
         e.due = cyc + 32'd1;
         exp_q.push_back(e);
      end
      @(posedge i_clock);
      #1;
      bif.valid = 1'b0;
      bif.sof   = 1'b0;
      bif.eof   = 1'b0;
   endtask

   // Reference: blocks pair up by index within the message; pair p has
   // zero feedback iff p == 0; a lone last block uses {H, 0}.
   task automatic send_msg(input int n, input int gap_max, input bit fixed_acc,
                           input blk_t acc_val);
      blk_t even_blk;
      exp_t e;
      even_blk = '0;
      h  = rnd_blk();
      h2 = rnd_blk();
      for (int i = 0; i < n; i++) begin
         blk_t d;
         blk_t a;
         logic sof, eof;
         int   gap;
         d   = rnd_blk();
         a   = fixed_acc ? acc_val : rnd_blk();
         gap = (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max));
         if (gap > 0) idle(gap);
         eof = (i == n - 1);
         if (i == 0)          sof = 1'b1;
         else if (i % 2 == 1) sof = 1'($urandom_range(0, 1));
         else                 sof = 1'b0;
         if (i % 2 == 0) even_blk = d;
         e.even = even_blk;
         e.odd  = (i % 2 == 1) ? d : '0;
         e.pair = (i % 2 == 1) ? {h2, h} : {h, ZERO_BLOCK};
         e.fb   = (i / 2 == 0) ? '0 : a;
         e.last = eof;
         e.due  = '0;
         put(d, sof, eof, a, (i % 2 == 1) || eof, e);
      end
   endtask

   task automatic pulse_reset();
      i_reset = 1'b1;
      #1;
      check("async_rst_flags", {o_valid, o_last, o_stall, bif.ready}, 4'b0001);
      check("async_rst_data", o_data_x_even | o_data_x_odd | o_feedback_mux, 0);
      check("async_rst_pair", o_h_pow_pair, 0);
      @(posedge i_clock);
      @(posedge i_clock);
      #1;
      i_reset = 1'b0;
   endtask

   // Monitor / scoreboard
   always @(negedge i_clock) begin
      if (i_reset) begin
         remaining = 0;
         check("rst_flags", {o_valid, o_last, o_stall, bif.ready}, 4'b0001);
         check("rst_data", o_data_x_even | o_data_x_odd | o_feedback_mux, 0);
      end else begin
         if (o_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_valid", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("issue_cycle", cyc, mon_e.due);
               check("x_even", o_data_x_even, mon_e.even);
               check("x_odd", o_data_x_odd, mon_e.odd);
               check("h_pow_pair", o_h_pow_pair, mon_e.pair);
               check("feedback", o_feedback_mux, mon_e.fb);
               check("last", o_last, mon_e.last);
               if (!mon_e.last) remaining = FB_LAT;
            end
         end
         check("ready", bif.ready, remaining == 0);
         check("stall", o_stall, remaining != 0);
         if (remaining > 0) remaining--;
      end
   end

   initial begin
      exp_t e;
      e          = '0;
      bif.valid  = 1'b0;
      bif.sof    = 1'b0;
      bif.eof    = 1'b0;
      bif.data_block = '0;
      h   = '0;
      h2  = '0;
      acc = '0;
      repeat (2) @(posedge i_clock);
      #1;
      i_reset = 1'b0;
      idle(1);

      send_msg(2, 0, 1'b0, '0);                 // two-block message
      idle(2);
      send_msg(4, 0, 1'b1, blk_t'(16'h1234));   // four-block, acc = 0x1234
      idle(2);
      send_msg(3, 0, 1'b0, '0);                 // three-block, leftover
      send_msg(1, 0, 1'b0, '0);                 // sof+eof single block
      send_msg(2, 0, 1'b0, '0);                 // back-to-back next message
      idle(3);

      // Reset while holding an even block
      put(rnd_blk(), 1'b1, 1'b0, rnd_blk(), 1'b0, e);
      #2;
      pulse_reset();
      idle(2);

      // Reset during the feedback wait
      send_msg(2, 0, 1'b0, '0);
      h = rnd_blk();
      h2 = rnd_blk();
      e.even = rnd_blk();
      e.odd  = rnd_blk();
      e.pair = {h2, h};
      e.fb   = '0;
      e.last = 1'b0;
      put(e.even, 1'b1, 1'b0, rnd_blk(), 1'b0, e);
      put(e.odd, 1'b0, 1'b0, rnd_blk(), 1'b1, e);
      @(negedge i_clock);
      #2;
      pulse_reset();
      idle(2);

      // Five-cycle valid gap between even and odd
      h  = rnd_blk();
      h2 = rnd_blk();
      e.even = rnd_blk();
      e.odd  = rnd_blk();
      e.pair = {h2, h};
      e.fb   = '0;
      e.last = 1'b1;
      put(e.even, 1'b1, 1'b0, rnd_blk(), 1'b0, e);
      idle(5);
      put(e.odd, 1'b0, 1'b1, rnd_blk(), 1'b1, e);
      idle(2);

      repeat (40) send_msg(int'($urandom_range(1, 7)), 3, 1'b0, '0);

      idle(FB_LAT + 6);
      check("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
